seq_mult_ctrl: RTL and testbench
================================

// Module: seq_mult_ctrl
// PURPOSE
//  Iterative unsigned shift-add multiplier: FSM + counter that sequence a
//  product register through a 3:1 select (hold / load / shift-add).
//  Sits between a start/done requester and the 2*WIDTH product register.
//  One multiply in flight; operands captured at start.
// PARAMETERS
//  WIDTH  8  operand width in bits; product is 2*WIDTH bits
// PORTS
//  clk       in   1          single clock, all state on posedge
//  reset     in   1          synchronous, active-high
//  start     in   1          request; sampled only in IDLE
//  mcand     in   WIDTH      multiplicand, captured when start accepted
//  mplier    in   WIDTH      multiplier, captured when start accepted
//  busy      out  1          high in LOAD, RUN, DONE
//  done      out  1          1-cycle pulse in DONE; product valid
//  product   out  2*WIDTH    product register P
//  prod_sel  out  2          P next-value select: 00 hold, 01 load, 1x shift-add
// BEHAVIOUR
//  Reset: state=IDLE, P=0, cnt=0, operand regs=0, busy=0, done=0, prod_sel=00.
//  Reset mid-operation aborts the multiply; no done pulse; P cleared.
//  States / transitions:
//   IDLE: prod_sel=00. start=1 at edge k -> capture mcand/mplier, go LOAD.
//   LOAD (cycle k+1): prod_sel=01, P<={WIDTH'0, mplier_r}, cnt<=WIDTH -> RUN.
//   RUN: prod_sel=10; sum[WIDTH:0] = P[2W-1:W] + (P[0] ? mcand_r : 0);
//        P <= {sum, P[W-1:0]} >> 1; cnt<=cnt-1; cnt==1 -> DONE.
//   DONE: done=1, prod_sel=00, P held -> IDLE.
//  Latency (base): start edge k -> DONE during cycle k+WIDTH+2; busy high
//   WIDTH+2 cycles. Next start accepted at the edge ending DONE+1 (IDLE).
//  P holds the final result after DONE until the next LOAD.
//  start while busy (LOAD/RUN/DONE): ignored, not queued; operands ignored.
//  Arithmetic unsigned; carry kept in sum[WIDTH]; (2^W-1)^2 fits, no overflow.
//  cnt width = $clog2(WIDTH+1); never wraps (stops at 1 -> DONE).
//  prod_sel is a registered-state decode (Moore), glitch-free per cycle.
// CONFIGURATION
//  EARLY_TERM_EN defined: in RUN, if remaining multiplier bits P[cnt-1:0]==0,
//   that cycle performs alignment P <= P >> cnt (still prod_sel=10), cnt<=0,
//   go DONE. Latency = 2 + RUN cycles taken (min 1 RUN cycle).
//  EARLY_TERM_EN undefined: always exactly WIDTH RUN cycles; no zero-detect
//   or variable-shift logic synthesised.
//  Result value identical in both configurations.
// TESTING (WIDTH=8)
//  reset, start 13*11 -> done at start+10, product=143 (0x008F), busy 10 cycles
//  start 255*255 -> product=0xFE01; done single-cycle; P held 5 idle cycles
//  prod_sel trace for one op -> 00,01,10 x8,00; done only in final 00 cycle
//  start 7*9 then start=1 with 3*3 during RUN -> product=63; 3*3 never issued
//  reset high mid-RUN (cycle 5) -> next cycle busy=0,done=0,P=0; 2*3 then -> 6
//  EARLY_TERM_EN: 200*0 -> done at start+3, P=0; 13*1 -> done at start+4, P=13

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: iterative unsigned shift-add multiplier controller.
//
// A four-state FSM (idle/load/run/done) and a down-counter sequence a 2*WIDTH
// product register P through a 3:1 next-value select (hold / load / shift-add).
// Operands are captured when start is accepted in idle. One multiply is in
// flight at a time; start is ignored while busy.
//
// Optional feature: define EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero. In that cycle P is aligned by a variable
// right shift and the FSM goes straight to done. The result is unchanged.
// Without the macro, every multiply takes exactly WIDTH run cycles.
//
// Ports:
//   clk       clock, all state on posedge
//   reset     synchronous, active-high
//   start     multiply request, sampled only in idle
//   mcand     multiplicand, captured on accepted start
//   mplier    multiplier, captured on accepted start
//   busy      high in load, run and done
//   done      one-cycle pulse in done; product valid
//   product   product register P
//   prod_sel  P next-value select: 00 hold, 01 load, 1x shift-add

module seq_mult_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         prod_sel
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mplier_q;
    logic [WIDTH:0]     sum;
    logic               accept;

    assign accept = (state_q == StIdle) && start;

`ifdef EARLY_TERM_EN
    // cnt_q is 1..WIDTH in run, so the mask covers exactly the multiplier
    // bits not yet consumed; shifting by WIDTH yields an all-ones mask.
    logic [WIDTH-1:0] rem_mask;
    logic             rem_zero;

    always_comb begin
        rem_mask = ~({WIDTH{1'b1}} << cnt_q);
        rem_zero = (prod_q[WIDTH-1:0] & rem_mask) == '0;
    end
`endif

    // Next state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                cnt_d   = CW'(WIDTH);
                state_d = StRun;
            end
            StRun: begin
`ifdef EARLY_TERM_EN
                if (rem_zero) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else
`endif
                begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        prod_sel = 2'b00;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StLoad: prod_sel = 2'b01;
            StRun:  prod_sel = 2'b10;
            StDone: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Product register datapath: 3:1 select driven by prod_sel
    always_comb begin
        // Upper half plus optional multiplicand; carry lands in sum[WIDTH]
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = prod_q;
        unique casez (prod_sel)
            2'b00: prod_d = prod_q;
            2'b01: prod_d = {{WIDTH{1'b0}}, mplier_q};
            2'b1?: begin
`ifdef EARLY_TERM_EN
                if (rem_zero) prod_d = prod_q >> cnt_q;
                else          prod_d = {sum, prod_q[WIDTH-1:1]};
`else
                prod_d = {sum, prod_q[WIDTH-1:1]};
`endif
            end
            default: prod_d = prod_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            prod_q   <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                mcand_q  <= mcand;
                mplier_q <= mplier;
            end
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: scoreboard bench for seq_mult_ctrl (WIDTH=8).
// Stimulus pushes expected product and done cycle; a negedge monitor pops and
// compares whenever done is seen. Honours EARLY_TERM_EN for expected latency.

module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [1:0]  prod_sel;

    seq_mult_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mcand    (mcand),
        .mplier   (mplier),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .prod_sel (prod_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;
    logic       prev_done = 1'b0;
    logic       rec_en = 1'b0;
    int         busy_run = 0;
    logic [2:0] trace[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (prev_done) check("done_single_cycle", 32'(done), 32'd0);
        prev_done = done;
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("product", 32'(product), 32'(e.prod));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Busy-length and prod_sel/done trace recorder
    always @(negedge clk) begin
        if (rec_en && busy) begin
            busy_run++;
            trace.push_back({done, prod_sel});
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                         input int lat, input bit push);
        @(posedge clk); #1;
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        if (push) sb.push_back('{prod: exp, cyc: cyc + lat});
        @(posedge clk); #1;
        start  = 1'b0;
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // Hand-computed latencies (start edge to done cycle)
`ifdef EARLY_TERM_EN
    localparam int LAT_13X11 = 7;
    localparam int LAT_FFXFF = 10;
    localparam int LAT_7X9   = 7;
    localparam int LAT_2X3   = 5;
    localparam int LAT_200X0 = 3;
    localparam int LAT_13X1  = 4;
    localparam int LAT_1XFF  = 10;
    localparam int LAT_128X2 = 5;
`else
    localparam int LAT_13X11 = 10;
    localparam int LAT_FFXFF = 10;
    localparam int LAT_7X9   = 10;
    localparam int LAT_2X3   = 10;
    localparam int LAT_200X0 = 10;
    localparam int LAT_13X1  = 10;
    localparam int LAT_1XFF  = 10;
    localparam int LAT_128X2 = 10;
`endif

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = 8'd0;
        mplier = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_prod_sel", 32'(prod_sel), 32'd0);
        reset = 1'b0;

        // 13*11 with busy length and prod_sel trace
        busy_run = 0;
        trace.delete();
        rec_en = 1'b1;
        issue(8'd13, 8'd11, 16'd143, LAT_13X11, 1'b1);
        wait_idle();
        rec_en = 1'b0;
        check("busy_cycles", busy_run, LAT_13X11);
        check("trace_len", trace.size(), LAT_13X11);
        for (int i = 0; i < trace.size(); i++) begin
            if (i == 0)                   check("trace_load", 32'(trace[i]), 32'b001);
            else if (i == trace.size()-1) check("trace_done", 32'(trace[i]), 32'b100);
            else                          check("trace_run", 32'(trace[i]), 32'b010);
        end

        // 255*255, then P held through idle
        issue(8'd255, 8'd255, 16'hFE01, LAT_FFXFF, 1'b1);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_product", 32'(product), 32'hFE01);
        end

        // 7*9, then start with 3*3 while running must be ignored
        issue(8'd7, 8'd9, 16'd63, LAT_7X9, 1'b1);
        start  = 1'b1;
        mcand  = 8'd3;
        mplier = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("no_queued_start", 32'(busy), 32'd0);
        check("product_7x9_held", 32'(product), 32'd63);

        // Reset during run aborts: no done, P cleared
        issue(8'd5, 8'h55, 16'd0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_prod_sel", 32'(prod_sel), 32'd0);
        reset = 1'b0;
        issue(8'd2, 8'd3, 16'd6, LAT_2X3, 1'b1);
        wait_idle();

        // Zero and short multipliers, plus carry/edge patterns
        issue(8'd200, 8'd0, 16'd0, LAT_200X0, 1'b1);
        wait_idle();
        issue(8'd13, 8'd1, 16'd13, LAT_13X1, 1'b1);
        wait_idle();
        issue(8'd1, 8'd255, 16'd255, LAT_1XFF, 1'b1);
        wait_idle();
        issue(8'd128, 8'd2, 16'h0100, LAT_128X2, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
